regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 Port: req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 Port: req0_addr  input  5  requester 0 destination register index.
REQ-006 Port: req0_data  input  32  requester 0 write data.
REQ-007 Port: req0_ready  output  1  requester 0 write accepted this cycle.
REQ-008 Port: req1_valid / req1_addr / req1_data / req1_ready  in/in/in/out  1/5/32/1  requester 1 (load unit), same meaning as requester 0.
REQ-009 Port: wr_stall  input  1  blocks all acceptances while 1.
REQ-010 Port: wr_sel  output  32  one-hot Select vector, bit n drives Select of register n.
REQ-011 Port: wr_data  output  32  data presented to the in port of every register.
REQ-012 Port: last_grant  output  1  index of the most recently granted requester.
REQ-013 Port: wr_count  output  16  number of accepted writes, including writes to x0.

Function
REQ-014 A transfer on requester k SHALL occur in a cycle where reqk_valid=1 and reqk_ready=1 at the rising clk edge.
REQ-015 reqk_ready SHALL be combinational from the valid inputs, wr_stall and last_grant; at most one ready is 1 per cycle.
REQ-016 wr_stall=1 SHALL force req0_ready=req1_ready=0.
REQ-017 With wr_stall=0 and only one valid, that requester SHALL get ready=1.
REQ-018 With wr_stall=0 and both valid, the requester with index != last_grant SHALL get ready=1 (round-robin).
REQ-019 With no valid inputs, both ready outputs SHALL be 0.
REQ-020 On each transfer, last_grant SHALL update to the granted index at that clk edge; otherwise it holds.
REQ-021 Output stage latency SHALL be 1 cycle: after a transfer at edge N, wr_sel and wr_data hold the accepted values for the cycle N..N+1.
REQ-022 wr_sel SHALL be the one-hot decode of the accepted addr (bit addr=1, all others 0), registered.
REQ-023 An accepted write to addr 0 SHALL give wr_sel=32'h0; it still counts as a transfer and updates last_grant.
REQ-024 In any cycle following an edge with no transfer, wr_sel SHALL be 32'h0, and wr_data SHALL hold its last value.
REQ-025 wr_sel SHALL never have more than one bit set.
REQ-026 wr_count SHALL increment by 1 on every transfer and wrap from 16'hFFFF to 16'h0000.
REQ-027 Both requesters valid with the same addr SHALL be serialised by round-robin; the later write lands one cycle after the earlier one.
REQ-028 A requester SHALL hold valid/addr/data stable until ready; the arbiter makes no guarantee for inputs changed before acceptance.
REQ-029 Request inputs SHALL not combinationally affect wr_sel or wr_data.

Reset
REQ-030 While rst=0, the block SHALL immediately (no clock needed) force wr_sel=32'h0, wr_data=32'h0, last_grant=1, wr_count=16'h0.
REQ-031 With last_grant=1 at reset, requester 0 SHALL win the first contended cycle after reset release.
REQ-032 While rst=0, req0_ready and req1_ready SHALL be 0.
REQ-033 rst asserted mid-write SHALL drop the pending wr_sel pulse; the write does not occur and is not counted.

Verification
REQ-034 Reset then single write: rst 0->1, req0 valid addr=5 data=A5A5A5A5 for 1 cycle -> req0_ready=1; next cycle wr_sel=32'h00000020, wr_data=A5A5A5A5; following cycle wr_sel=0; wr_count=1.
REQ-035 Contention: both valid every cycle, req0 addr=3, req1 addr=7, for 4 cycles -> grants 0,1,0,1; wr_sel sequence 0x8, 0x80, 0x8, 0x80; wr_count=4.
REQ-036 x0 write: req1 valid addr=0 data=5A5A5A5A -> req1_ready=1, wr_sel stays 0, wr_count increments, last_grant=1.
REQ-037 Stall: wr_stall=1 with both valid for 3 cycles -> both ready=0, wr_sel=0, wr_count unchanged; wr_stall 1->0 -> grant goes to index != last_grant.
REQ-038 Async reset mid-operation: rst=0 between edges while wr_sel=0x20 -> wr_sel=0, wr_count=0 before the next edge; first contended grant after release is requester 0.
REQ-039 Wrap: preload 65535 transfers (or force count) then one more transfer -> wr_count=16'h0000.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester round-robin register-file write arbiter
//
// Arbitrates writes from the ALU writeback (requester 0) and the load unit
// (requester 1) onto the shared register-file write port. It registers a
// one-hot select vector and the write data one cycle after acceptance.
//
// Ports:
//   clk                     rising-edge clock
//   rst                     asynchronous reset, active-low
//   req0_valid/addr/data    requester 0 write request (ALU writeback)
//   req0_ready              requester 0 accepted this cycle (combinational)
//   req1_valid/addr/data    requester 1 write request (load unit)
//   req1_ready              requester 1 accepted this cycle (combinational)
//   wr_stall                blocks all acceptances while high
//   wr_sel                  registered one-hot register select (x0 -> none)
//   wr_data                 registered data for the register input bus
//   last_grant              index of the most recently granted requester
//   wr_count                accepted-write counter, wraps at 16 bits

module regfile_wr_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        wr_stall,
    output logic [31:0] wr_sel,
    output logic [31:0] wr_data,
    output logic        last_grant,
    output logic [15:0] wr_count
);

    logic        grant0;
    logic        grant1;
    logic [4:0]  acc_addr;
    logic [31:0] acc_data;
    logic [31:0] sel_dec;

    // Round-robin: under contention the requester that did not win last time
    // is served. Ready is held low during reset so nothing is accepted while
    // the state registers are being cleared.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && !wr_stall) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign acc_addr = grant1 ? req1_addr : req0_addr;
    assign acc_data = grant1 ? req1_data : req0_data;

    // x0 is hardwired to zero, so a write to it selects no register at all.
    assign sel_dec = (acc_addr == 5'd0) ? 32'h0 : (32'h1 << acc_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sel     <= 32'h0;
            wr_data    <= 32'h0;
            last_grant <= 1'b1;
            wr_count   <= 16'h0;
        end else if (grant0 || grant1) begin
            wr_sel     <= sel_dec;
            wr_data    <= acc_data;
            last_grant <= grant1;
            wr_count   <= wr_count + 16'd1;
        end else begin
            // Select is a single-cycle pulse; data is left on the bus.
            wr_sel <= 32'h0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter

module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        wr_stall;
    logic [31:0] wr_sel;
    logic [31:0] wr_data;
    logic        last_grant;
    logic [15:0] wr_count;

    int checks;
    int errors;

    regfile_wr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_stall   (wr_stall),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .last_grant (last_grant),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wr_stall   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'h0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'h0;
        wr_stall = 1'b0;

        // Reset state, with a request present to show ready stays low.
        step();
        req0_valid = 1'b1;
        req0_addr  = 5'd5;
        #1;
        check("rst_wr_sel", wr_sel, 32'h0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_last_grant", {31'b0, last_grant}, 32'h1);
        check("rst_wr_count", {16'b0, wr_count}, 32'h0);
        check("rst_ready0", {31'b0, req0_ready}, 32'h0);
        check("rst_ready1", {31'b0, req1_ready}, 32'h0);

        // Single write after reset release.
        step();
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hA5A5A5A5;
        #1;
        check("single_ready0", {31'b0, req0_ready}, 32'h1);
        check("single_ready1", {31'b0, req1_ready}, 32'h0);
        step();
        req0_valid = 1'b0;
        check("single_sel", wr_sel, 32'h00000020);
        check("single_data", wr_data, 32'hA5A5A5A5);
        check("single_count", {16'b0, wr_count}, 32'd1);
        check("single_lg", {31'b0, last_grant}, 32'h0);
        step();
        check("single_sel_clr", wr_sel, 32'h0);
        check("single_data_hold", wr_data, 32'hA5A5A5A5);
        check("single_count_hold", {16'b0, wr_count}, 32'd1);

        // Contention after a fresh reset: grants alternate starting with 0.
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11111111;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h22222222;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont_ready0_%0d", i), {31'b0, req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("cont_ready1_%0d", i), {31'b0, req1_ready}, (i % 2 == 1) ? 32'h1 : 32'h0);
            step();
            check($sformatf("cont_sel_%0d", i), wr_sel, (i % 2 == 0) ? 32'h8 : 32'h80);
            check($sformatf("cont_data_%0d", i), wr_data, (i % 2 == 0) ? 32'h11111111 : 32'h22222222);
        end
        check("cont_count", {16'b0, wr_count}, 32'd4);
        check("cont_lg", {31'b0, last_grant}, 32'h1);

        // Write to x0 from requester 1.
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h5A5A5A5A;
        #1;
        check("x0_ready1", {31'b0, req1_ready}, 32'h1);
        step();
        req1_valid = 1'b0;
        check("x0_sel", wr_sel, 32'h0);
        check("x0_data", wr_data, 32'h5A5A5A5A);
        check("x0_count", {16'b0, wr_count}, 32'd5);
        check("x0_lg", {31'b0, last_grant}, 32'h1);

        // Stall with both valid for three cycles.
        wr_stall = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hA5A5A5A5;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h22222222;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_ready0_%0d", i), {31'b0, req0_ready}, 32'h0);
            check($sformatf("stall_ready1_%0d", i), {31'b0, req1_ready}, 32'h0);
            step();
            check($sformatf("stall_sel_%0d", i), wr_sel, 32'h0);
            check($sformatf("stall_count_%0d", i), {16'b0, wr_count}, 32'd5);
        end
        wr_stall = 1'b0;
        #1;
        check("unstall_ready0", {31'b0, req0_ready}, 32'h1);
        check("unstall_ready1", {31'b0, req1_ready}, 32'h0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("unstall_sel", wr_sel, 32'h00000020);
        check("unstall_count", {16'b0, wr_count}, 32'd6);

        // Asynchronous reset between edges while the select pulse is live.
        #2;
        rst = 1'b0;
        #1;
        check("arst_sel", wr_sel, 32'h0);
        check("arst_data", wr_data, 32'h0);
        check("arst_count", {16'b0, wr_count}, 32'h0);
        check("arst_lg", {31'b0, last_grant}, 32'h1);

        // Release, then same-address contention: requester 0 first.
        step();
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hCAFE0000;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hBEEF0001;
        #1;
        check("same_ready0", {31'b0, req0_ready}, 32'h1);
        step();
        req0_valid = 1'b0;
        check("same_sel0", wr_sel, 32'h00000200);
        check("same_data0", wr_data, 32'hCAFE0000);
        #1;
        check("same_ready1", {31'b0, req1_ready}, 32'h1);
        step();
        req1_valid = 1'b0;
        check("same_sel1", wr_sel, 32'h00000200);
        check("same_data1", wr_data, 32'hBEEF0001);
        check("same_count", {16'b0, wr_count}, 32'd2);

        // Counter wrap: 65535 back-to-back transfers, then one more.
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h00000001;
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        check("wrap_pre", {16'b0, wr_count}, 32'h0000FFFF);
        check("wrap_sel", wr_sel, 32'h00000002);
        step();
        req0_valid = 1'b0;
        check("wrap_post", {16'b0, wr_count}, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
